// File: rtl/frame_scheduler_if.sv
// Byte-bus bundle between the frame scheduler, the scene exhibitor and the TFT serializer.
// The master side is the scheduler: it drives the panel bus and the exhibitor controls.
interface frame_scheduler_if;
    logic       tft_busy;
    logic       tft_dc;
    logic [7:0] tft_data;
    logic       tft_transmit;
    logic       scene_rst;
    logic       scene_enable;
    logic       scene_busy;
    logic       scene_dc;
    logic [7:0] scene_data;
    logic       scene_transmit;

    modport master (
        input  tft_busy, scene_busy, scene_dc, scene_data, scene_transmit,
        output tft_dc, tft_data, tft_transmit, scene_rst, scene_enable
    );

    modport slave (
        output tft_busy, scene_busy, scene_dc, scene_data, scene_transmit,
        input  tft_dc, tft_data, tft_transmit, scene_rst, scene_enable
    );
endinterface

// File: rtl/frame_scheduler.sv
// Sequences one full-screen redraw per request: snapshot maze state, send the window
// and RAMWR commands, restart the scene exhibitor, then lend it the bus until it drains.
module frame_scheduler #(
    parameter int unsigned X_END = 319,
    parameter int unsigned Y_END = 479
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic                 frame_req,
    input  logic [159:0]         h_walls_in,
    input  logic [164:0]         v_walls_in,
    input  logic [299:0]         food_in,
    output logic [159:0]         h_walls_out,
    output logic [164:0]         v_walls_out,
    output logic [299:0]         food_out,
    frame_scheduler_if.master    bus,
    output logic                 frame_busy,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DRAIN_CMD, S_SCENE_RST, S_SCENE_RUN, S_DONE
    } state_t;

    localparam logic [15:0] XE = X_END[15:0];
    localparam logic [15:0] YE = Y_END[15:0];

    state_t         state_q, state_d;
    logic           pending_q, pending_d;
    logic [3:0]     idx_q, idx_d;
    logic           cmd_tx_q, cmd_tx_d;
    logic           cmd_dc_q, cmd_dc_d;
    logic [7:0]     cmd_data_q, cmd_data_d;
    logic           sel_scene_q;
    logic           seen_busy_q, seen_busy_d;
    logic [1:0]     run_cnt_q, run_cnt_d;
    logic           load_snap;
    logic [159:0]   h_q;
    logic [164:0]   v_q;
    logic [299:0]   food_q;

    // {dc, byte}; dc=0 marks the CASET/RASET/RAMWR opcodes.
    function automatic logic [8:0] cmd_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_rom = {1'b0, 8'h2A};
            4'd3:    cmd_rom = {1'b1, XE[15:8]};
            4'd4:    cmd_rom = {1'b1, XE[7:0]};
            4'd5:    cmd_rom = {1'b0, 8'h2B};
            4'd8:    cmd_rom = {1'b1, YE[15:8]};
            4'd9:    cmd_rom = {1'b1, YE[7:0]};
            4'd10:   cmd_rom = {1'b0, 8'h2C};
            default: cmd_rom = {1'b1, 8'h00};
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | frame_req;
        idx_d       = idx_q;
        cmd_tx_d    = 1'b0;
        cmd_dc_d    = cmd_dc_q;
        cmd_data_d  = cmd_data_q;
        seen_busy_d = seen_busy_q;
        run_cnt_d   = run_cnt_q;
        load_snap   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (init_done && pending_q) begin
                    state_d   = S_CMD;
                    pending_d = frame_req;
                    idx_d     = 4'd0;
                    load_snap = 1'b1;
                end
            end
            S_CMD: begin
                // A strobe is never issued back-to-back, so the serializer has a cycle to raise busy.
                if (!bus.tft_busy && !cmd_tx_q) begin
                    cmd_tx_d               = 1'b1;
                    {cmd_dc_d, cmd_data_d} = cmd_rom(idx_q);
                    if (idx_q == 4'd10) begin
                        idx_d   = 4'd0;
                        state_d = S_DRAIN_CMD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_DRAIN_CMD: begin
                if (!cmd_tx_q && !bus.tft_busy) state_d = S_SCENE_RST;
            end
            S_SCENE_RST: begin
                seen_busy_d = 1'b0;
                run_cnt_d   = 2'd0;
                state_d     = S_SCENE_RUN;
            end
            S_SCENE_RUN: begin
                if (bus.scene_busy) seen_busy_d = 1'b1;
                if (run_cnt_q != 2'd3) run_cnt_d = run_cnt_q + 2'd1;
                if (seen_busy_q && !bus.scene_busy && !bus.tft_busy && !bus.scene_transmit)
                    state_d = S_DONE;
                // An exhibitor that never goes busy must not wedge the scheduler.
                else if (!seen_busy_q && !bus.scene_busy && run_cnt_q == 2'd3)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            idx_q       <= 4'd0;
            cmd_tx_q    <= 1'b0;
            cmd_dc_q    <= 1'b1;
            cmd_data_q  <= 8'h00;
            sel_scene_q <= 1'b0;
            seen_busy_q <= 1'b0;
            run_cnt_q   <= 2'd0;
            h_q         <= '0;
            v_q         <= '0;
            food_q      <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            cmd_tx_q    <= cmd_tx_d;
            cmd_dc_q    <= cmd_dc_d;
            cmd_data_q  <= cmd_data_d;
            sel_scene_q <= (state_d == S_SCENE_RUN);
            seen_busy_q <= seen_busy_d;
            run_cnt_q   <= run_cnt_d;
            if (load_snap) begin
                h_q    <= h_walls_in;
                v_q    <= v_walls_in;
                food_q <= food_in;
            end
        end
    end

    assign bus.tft_transmit = sel_scene_q ? bus.scene_transmit : cmd_tx_q;
    assign bus.tft_dc       = sel_scene_q ? bus.scene_dc       : cmd_dc_q;
    assign bus.tft_data     = sel_scene_q ? bus.scene_data     : cmd_data_q;
    assign bus.scene_rst    = (state_q != S_SCENE_RUN);
    assign bus.scene_enable = (state_q == S_SCENE_RUN);
    assign frame_busy       = (state_q != S_IDLE);
    assign frame_done       = (state_q == S_DONE);
    assign h_walls_out      = h_q;
    assign v_walls_out      = v_q;
    assign food_out         = food_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: serializer and exhibitor models, a frame-level reference
// model, directed table scenarios, hand sequences and a randomized run.
module tb_frame_scheduler;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init_done = 1'b0;
    logic         frame_req = 1'b0;
    logic [159:0] h_in = '0;
    logic [164:0] v_in = '0;
    logic [299:0] f_in = '0;
    logic [159:0] h_out;
    logic [164:0] v_out;
    logic [299:0] f_out;
    logic         frame_busy, frame_done;

    frame_scheduler_if bus();

    frame_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .frame_req   (frame_req),
        .h_walls_in  (h_in),
        .v_walls_in  (v_in),
        .food_in     (f_in),
        .h_walls_out (h_out),
        .v_walls_out (v_out),
        .food_out    (f_out),
        .bus         (bus),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected command stream for a 320x480 panel, {dc, byte}.
    logic [8:0] rom [11] = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
                             9'h02B, 9'h100, 9'h100, 9'h101, 9'h1DF, 9'h02C};

    // ---------------- serializer + exhibitor models ----------------
    int         busy_cnt = 0;
    int         ex_n = 4;
    bit         ex_dead = 0;
    int         ex_left = 0;
    bit         ex_started = 0;
    logic [8:0] ex_log [$];

    initial begin : models
        logic       b, tx_prev;
        logic [7:0] d;
        bus.tft_busy = 1'b0;
        bus.scene_busy = 1'b0;
        bus.scene_dc = 1'b1;
        bus.scene_data = 8'h00;
        bus.scene_transmit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            b = bus.tft_busy;
            if (!rst_n || bus.scene_rst) begin
                bus.scene_busy = 1'b0;
                bus.scene_transmit = 1'b0;
                ex_left = ex_n;
                ex_started = 0;
            end else if (bus.scene_enable) begin
                tx_prev = bus.scene_transmit;
                bus.scene_transmit = 1'b0;
                if (!ex_started) begin
                    if (!ex_dead) begin
                        ex_started = 1;
                        bus.scene_busy = 1'b1;
                    end
                end else if (bus.scene_busy) begin
                    if (ex_left > 0 && !b && !tx_prev) begin
                        d = 8'($urandom);
                        bus.scene_data = d;
                        bus.scene_transmit = 1'b1;
                        ex_log.push_back({1'b1, d});
                        ex_left--;
                    end else if (ex_left == 0 && !tx_prev) begin
                        bus.scene_busy = 1'b0;
                    end
                end
            end
            #1;
            if (busy_cnt > 0) busy_cnt--;
            if (bus.tft_transmit) busy_cnt = $urandom_range(1, 3);
            bus.tft_busy = (busy_cnt != 0);
        end
    end

    // ---------------- frame-level reference model + monitor ----------------
    bit           m_busy = 0, m_pending = 0;
    int           m_frames = 0, n_done = 0, n_strobes = 0;
    logic         prev_tx = 0, prev_busy = 0, prev_srst = 1, prev_en = 0;
    logic [159:0] m_h = '0;
    logic [164:0] m_v = '0;
    logic [299:0] m_f = '0;
    logic [8:0]   bus_q [$];

    initial begin : monitor
        logic [8:0] exp_q [$];
        int errs;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_pending = 0;
                m_h = '0; m_v = '0; m_f = '0;
                bus_q.delete(); ex_log.delete();
                prev_tx = 0; prev_busy = bus.tft_busy; prev_srst = 1; prev_en = 0;
            end else begin
                check("frame_busy", frame_busy, m_busy);
                check("snap_h", h_out, m_h);
                check("snap_v", v_out, m_v);
                check("snap_food", f_out, m_f);
                if (frame_done) check("done_outside_frame", m_busy, 1);
                if (bus.tft_transmit) begin
                    n_strobes++;
                    bus_q.push_back({bus.tft_dc, bus.tft_data});
                    check("strobe_spacing", prev_tx, 0);
                    check("strobe_while_busy", prev_busy, 0);
                end
                if (bus.scene_enable && !prev_en)
                    check("scene_rst_before_enable", {prev_srst, bus.scene_rst}, 2'b10);
                if (frame_done) begin
                    n_done++;
                    exp_q.delete();
                    foreach (rom[i]) exp_q.push_back(rom[i]);
                    foreach (ex_log[i]) exp_q.push_back(ex_log[i]);
                    check("frame_len", bus_q.size(), exp_q.size());
                    errs = 0;
                    foreach (bus_q[i]) if (i < exp_q.size() && bus_q[i] !== exp_q[i]) errs++;
                    check("frame_bytes", errs, 0);
                    bus_q.delete();
                    ex_log.delete();
                end
                if (m_busy && frame_done) begin
                    m_busy = 0;
                end else if (!m_busy && m_pending && init_done) begin
                    m_busy = 1; m_pending = 0; m_frames++;
                    m_h = h_in; m_v = v_in; m_f = f_in;
                end
                if (frame_req) m_pending = 1;
                prev_tx = bus.tft_transmit; prev_busy = bus.tft_busy;
                prev_srst = bus.scene_rst; prev_en = bus.scene_enable;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_inputs();
        for (int i = 0; i < 5; i++) h_in = {h_in[127:0], 32'($urandom)};
        for (int i = 0; i < 6; i++) v_in = {v_in[132:0], 32'($urandom)};
        for (int i = 0; i < 10; i++) f_in = {f_in[267:0], 32'($urandom)};
    endtask

    task automatic pulse_req();
        @(posedge clk); #1 frame_req = 1'b1;
        @(posedge clk); #1 frame_req = 1'b0;
    endtask

    task automatic wait_idle(input bit toggle);
        int idle = 0;
        for (int c = 0; c < 4000 && idle < 8; c++) begin
            @(posedge clk); #1;
            if (toggle) rand_inputs();
            @(negedge clk);
            idle = (!frame_busy && !m_pending) ? idle + 1 : 0;
        end
        if (idle < 8) check("wait_idle_timeout", 0, 1);
    endtask

    typedef struct {
        int n_req;
        int gap;
        int bytes;
        bit dead;
        int exp_frames;
    } vec_t;

    vec_t vecs [5];

    initial begin : stim
        int s0, d0, f0, k;
        logic [8:0] first;
        bit got;
        vecs[0] = '{1, 1, 4, 0, 1};
        vecs[1] = '{3, 7, 5, 0, 2};
        vecs[2] = '{2, 1, 3, 0, 2};
        vecs[3] = '{1, 1, 2, 1, 1};
        vecs[4] = '{5, 3, 0, 0, 2};

        rand_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tft_transmit", bus.tft_transmit, 0);
        check("rst_tft_dc", bus.tft_dc, 1);
        check("rst_tft_data", bus.tft_data, 0);
        check("rst_scene_rst", bus.scene_rst, 1);
        check("rst_scene_enable", bus.scene_enable, 0);
        check("rst_frame_busy", frame_busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_snap_food", f_out, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // request while the panel is still initialising
        s0 = n_strobes;
        pulse_req();
        repeat (100) @(posedge clk);
        #1;
        check("no_strobe_before_init", n_strobes - s0, 0);
        init_done = 1'b1;
        @(negedge clk);
        check("idle_until_edge", frame_busy, 0);
        @(posedge clk); @(negedge clk);
        check("cmd_start_latency", frame_busy, 1);
        wait_idle(1);
        check("first_frame_count", n_done, 1);

        foreach (vecs[i]) begin
            ex_n = vecs[i].bytes;
            ex_dead = vecs[i].dead;
            d0 = n_done;
            for (int c = 0; c < (vecs[i].n_req - 1) * vecs[i].gap + 1; c++) begin
                @(posedge clk); #1;
                rand_inputs();
                frame_req = (c % vecs[i].gap == 0);
            end
            @(posedge clk); #1 frame_req = 1'b0;
            wait_idle(1);
            check($sformatf("vec%0d_frames", i), n_done - d0, vecs[i].exp_frames);
            $display("vec %0d: %0d requests -> %0d frames", i, vecs[i].n_req, n_done - d0);
        end
        ex_dead = 0;
        ex_n = 3;

        // reset while the sixth command byte is on the bus
        pulse_req();
        k = 0;
        for (int c = 0; c < 500 && k < 6; c++) begin
            @(posedge clk); #3;
            if (bus.tft_transmit) k++;
        end
        check("reached_byte6", k, 6);
        rst_n = 1'b0;
        #1;
        check("reset_quiets_bus", bus.tft_transmit, 0);
        check("reset_frame_busy", frame_busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        d0 = n_done;
        pulse_req();
        got = 0;
        first = '0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk); #3;
            if (bus.tft_transmit) begin
                got = 1;
                first = {bus.tft_dc, bus.tft_data};
            end
        end
        check("restart_first_byte", first, 9'h02A);
        wait_idle(0);
        check("restart_frame_count", n_done - d0, 1);

        // randomized traffic against the reference model
        d0 = n_done;
        f0 = m_frames;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            rand_inputs();
            frame_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) init_done = ~init_done;
            if ($urandom_range(0, 49) == 0) ex_n = $urandom_range(0, 8);
        end
        @(posedge clk); #1;
        frame_req = 1'b0;
        init_done = 1'b1;
        wait_idle(0);
        check("random_frame_count", n_done - d0, m_frames - f0);
        $display("random run: %0d frames", n_done - d0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
